// File: rtl/keypad_scanner_buffered_if.sv
// Event/digit bus between the keypad scanner and the lock controller.
// The scanner owns the master side: it drives the digit buffer, count, event code,
// valid and the key pulse. The lock controller answers with ready.
interface keypad_scanner_buffered_if #(
   parameter int MAX_DIGITS = 20
);
   localparam int CW = $clog2(MAX_DIGITS + 1);

   logic [4*MAX_DIGITS-1:0] digitos_value;
   logic [CW-1:0]           digitos_count;
   logic [1:0]              digitos_event;
   logic                    digitos_valid;
   logic                    digitos_ready;
   logic                    key_pressed;

   modport master (
      output digitos_value,
      output digitos_count,
      output digitos_event,
      output digitos_valid,
      output key_pressed,
      input  digitos_ready
   );

   modport slave (
      input  digitos_value,
      input  digitos_count,
      input  digitos_event,
      input  digitos_valid,
      input  key_pressed,
      output digitos_ready
   );
endinterface

// File: rtl/keypad_scanner_buffered.sv
// 4x4 keypad scanner with press/release debounce and a nibble digit buffer.
// Confirm, clear and timeout results are held on a valid/ready handshake.
// Optional build macro KEYPAD_BACKSPACE_EN turns key C into backspace
// (when undefined, C is ignored like D/E/F).
module keypad_scanner_buffered #(
   parameter int MAX_DIGITS      = 20,
   parameter int DEBOUNCE_CYCLES = 100,
   parameter int SCAN_DIV        = 1,
   parameter int TIMEOUT_CYCLES  = 5000
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             enable,
   input  logic [3:0]                       col_matriz,
   output logic [3:0]                       lin_matriz,
   keypad_scanner_buffered_if.master        dig
);
   localparam int BW = 4 * MAX_DIGITS;
   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int SW = $clog2(SCAN_DIV + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] EVT_NONE    = 2'd0;
   localparam logic [1:0] EVT_CONFIRM = 2'd1;
   localparam logic [1:0] EVT_CLEAR   = 2'd2;
   localparam logic [1:0] EVT_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SCAN     = 3'd1,
      ST_DEBOUNCE = 3'd2,
      ST_DECODE   = 3'd3,
      ST_RELEASE  = 3'd4,
      ST_REPORT   = 3'd5
   } state_t;

   state_t          state_r, state_s;
   logic [1:0]      row_r, row_s;
   logic [SW-1:0]   div_r, div_s;
   logic [DW-1:0]   deb_r, deb_s;
   logic [TW-1:0]   to_r, to_s;
   logic [3:0]      col_lat_r, col_lat_s;
   logic [BW-1:0]   buf_r, buf_s;
   logic [CW-1:0]   cnt_r, cnt_s;
   logic [1:0]      evt_r, evt_s;
   logic            valid_r, valid_s;
   logic            kp_r, kp_s;
   logic [3:0]      lin_r, lin_s;
   logic [1:0]      col_idx_s;
   logic            multi_s;
   logic [3:0]      key_s;

   // Keypad legend: row0 1 2 3 C, row1 4 5 6 D, row2 7 8 9 E, row3 A 0 B F
   function automatic logic [3:0] key_decode(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] k;
      case ({row, col})
         4'b00_00: k = 4'h1;
         4'b00_01: k = 4'h2;
         4'b00_10: k = 4'h3;
         4'b00_11: k = 4'hC;
         4'b01_00: k = 4'h4;
         4'b01_01: k = 4'h5;
         4'b01_10: k = 4'h6;
         4'b01_11: k = 4'hD;
         4'b10_00: k = 4'h7;
         4'b10_01: k = 4'h8;
         4'b10_10: k = 4'h9;
         4'b10_11: k = 4'hE;
         4'b11_00: k = 4'hA;
         4'b11_01: k = 4'h0;
         4'b11_10: k = 4'hB;
         4'b11_11: k = 4'hF;
         default:  k = 4'hF;
      endcase
      return k;
   endfunction

   // Column index of the latched pattern; anything but a single low column is a chord
   always_comb begin
      col_idx_s = 2'd0;
      multi_s   = 1'b0;
      case (col_lat_r)
         4'b0111: col_idx_s = 2'd0;
         4'b1011: col_idx_s = 2'd1;
         4'b1101: col_idx_s = 2'd2;
         4'b1110: col_idx_s = 2'd3;
         default: multi_s   = 1'b1;
      endcase
      key_s = key_decode(row_r, col_idx_s);
   end

   // Next-state and datapath: every register holds unless its state says otherwise
   always_comb begin
      state_s   = state_r;
      row_s     = row_r;
      div_s     = div_r;
      deb_s     = deb_r;
      to_s      = to_r;
      col_lat_s = col_lat_r;
      buf_s     = buf_r;
      cnt_s     = cnt_r;
      evt_s     = evt_r;
      valid_s   = valid_r;
      kp_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            state_s = ST_SCAN;
            div_s   = '0;
         end
         ST_SCAN: begin
            if (col_matriz != 4'b1111) begin
               // The detecting cycle counts as the first stable cycle
               state_s   = ST_DEBOUNCE;
               col_lat_s = col_matriz;
               deb_s     = DW'(1);
            end else begin
               if (div_r >= SW'(SCAN_DIV - 1)) begin
                  div_s = '0;
                  row_s = row_r + 2'd1;
               end else begin
                  div_s = div_r + SW'(1);
               end
               if (cnt_r == '0) begin
                  to_s = to_r;
               end else if (to_r >= TW'(TIMEOUT_CYCLES - 1)) begin
                  state_s = ST_REPORT;
                  evt_s   = EVT_TIMEOUT;
                  valid_s = 1'b1;
                  buf_s   = {MAX_DIGITS{4'hE}};
               end else begin
                  to_s = to_r + TW'(1);
               end
            end
         end
         ST_DEBOUNCE: begin
            if (col_matriz != col_lat_r) begin
               state_s = ST_SCAN;
               deb_s   = '0;
               div_s   = '0;
            end else if (deb_r >= DW'(DEBOUNCE_CYCLES - 1)) begin
               state_s = ST_DECODE;
               deb_s   = '0;
            end else begin
               deb_s = deb_r + DW'(1);
            end
         end
         ST_DECODE: begin
            state_s = ST_RELEASE;
            if (multi_s) begin
               buf_s = buf_r;
            end else if (key_s <= 4'h9) begin
               // A full buffer drops the digit but the key is still acknowledged
               kp_s = 1'b1;
               if (cnt_r < CW'(MAX_DIGITS)) begin
                  buf_s = BW'({buf_r, key_s});
                  cnt_s = cnt_r + CW'(1);
                  to_s  = '0;
               end else begin
                  buf_s = buf_r;
               end
            end else if (key_s == 4'hA) begin
               state_s = ST_REPORT;
               evt_s   = EVT_CONFIRM;
               valid_s = 1'b1;
            end else if (key_s == 4'hB) begin
               state_s = ST_REPORT;
               evt_s   = EVT_CLEAR;
               valid_s = 1'b1;
               buf_s   = {MAX_DIGITS{4'hF}};
            end else if (key_s == 4'hC) begin
`ifdef KEYPAD_BACKSPACE_EN
               if (cnt_r != '0) begin
                  buf_s = BW'({4'hF, buf_r} >> 4);
                  cnt_s = cnt_r - CW'(1);
                  kp_s  = 1'b1;
                  to_s  = '0;
               end else begin
                  buf_s = buf_r;
               end
`else
               buf_s = buf_r;
`endif
            end else begin
               buf_s = buf_r;
            end
         end
         ST_RELEASE: begin
            if (col_matriz != 4'b1111) begin
               deb_s = '0;
            end else if (deb_r >= DW'(DEBOUNCE_CYCLES - 1)) begin
               state_s = ST_SCAN;
               deb_s   = '0;
               div_s   = '0;
            end else begin
               deb_s = deb_r + DW'(1);
            end
         end
         ST_REPORT: begin
            if (dig.digitos_ready) begin
               valid_s = 1'b0;
               evt_s   = EVT_NONE;
               buf_s   = {MAX_DIGITS{4'hF}};
               cnt_s   = '0;
               to_s    = '0;
               deb_s   = '0;
               div_s   = '0;
               if (evt_r == EVT_TIMEOUT) begin
                  state_s = ST_SCAN;
               end else begin
                  state_s = ST_RELEASE;
               end
            end else begin
               valid_s = 1'b1;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Row drive follows the next state so the pins line up with the state register
   always_comb begin
      case (state_s)
         ST_SCAN, ST_DEBOUNCE, ST_DECODE, ST_RELEASE: lin_s = ~(4'b1000 >> row_s);
         default:                                     lin_s = 4'b1111;
      endcase
   end

   // State and output registers; rst wins, enable low is a soft reset
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         state_r   <= ST_IDLE;
         row_r     <= 2'd0;
         div_r     <= '0;
         deb_r     <= '0;
         to_r      <= '0;
         col_lat_r <= 4'b1111;
         buf_r     <= {MAX_DIGITS{4'hF}};
         cnt_r     <= '0;
         evt_r     <= EVT_NONE;
         valid_r   <= 1'b0;
         kp_r      <= 1'b0;
         lin_r     <= 4'b1111;
      end else begin
         state_r   <= state_s;
         row_r     <= row_s;
         div_r     <= div_s;
         deb_r     <= deb_s;
         to_r      <= to_s;
         col_lat_r <= col_lat_s;
         buf_r     <= buf_s;
         cnt_r     <= cnt_s;
         evt_r     <= evt_s;
         valid_r   <= valid_s;
         kp_r      <= kp_s;
         lin_r     <= lin_s;
      end
   end

   assign lin_matriz        = lin_r;
   assign dig.digitos_value = buf_r;
   assign dig.digitos_count = cnt_r;
   assign dig.digitos_event = evt_r;
   assign dig.digitos_valid = valid_r;
   assign dig.key_pressed   = kp_r;
endmodule

// File: tb/tb_keypad_scanner_buffered.sv
// Directed bench for keypad_scanner_buffered with a keypad matrix model and an
// event scoreboard (expected events queued when the key is pressed).
module tb_keypad_scanner_buffered;
   logic       clk;
   logic       rst;
   logic       enable;
   logic [3:0] col_matriz;
   logic [3:0] lin_matriz;
   logic       key_down;
   logic [1:0] key_row;
   logic [1:0] key_col;
   int         errors;
   int         checks;
   int         kp_cnt;
   bit         post_hs;

   typedef struct {
      logic [1:0]  evt;
      logic [15:0] value;
      int          count;
   } exp_t;
   exp_t sb_q[$];

   keypad_scanner_buffered_if #(.MAX_DIGITS(4)) dig ();

   keypad_scanner_buffered #(
      .MAX_DIGITS(4), .DEBOUNCE_CYCLES(4), .SCAN_DIV(2), .TIMEOUT_CYCLES(200)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .col_matriz(col_matriz), .lin_matriz(lin_matriz), .dig(dig)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix: a held key pulls its column low only while its row is driven
   always_comb begin
      col_matriz = 4'b1111;
      if (key_down && (lin_matriz[2'd3 - key_row] == 1'b0)) col_matriz[2'd3 - key_col] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sample();
      exp_t e;
      if (post_hs) begin
         check("post_hs_valid", {31'd0, dig.digitos_valid}, 32'd0);
         check("post_hs_value", {16'd0, dig.digitos_value}, 32'h0000FFFF);
         check("post_hs_count", {29'd0, dig.digitos_count}, 32'd0);
         post_hs = 1'b0;
      end
      if (dig.key_pressed) kp_cnt++;
      if (dig.digitos_valid && dig.digitos_ready) begin
         check("sb_pending", {31'd0, (sb_q.size() != 0)}, 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("ev_event", {30'd0, dig.digitos_event}, {30'd0, e.evt});
            check("ev_value", {16'd0, dig.digitos_value}, {16'd0, e.value});
            if (e.count >= 0) check("ev_count", {29'd0, dig.digitos_count}, e.count);
         end
         post_hs = 1'b1;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
   endtask

   task automatic push_exp(input logic [1:0] ev, input logic [15:0] v, input int c);
      exp_t e;
      e.evt = ev; e.value = v; e.count = c;
      sb_q.push_back(e);
   endtask

   task automatic set_key(input logic [3:0] k);
      case (k)
         4'h1: begin key_row = 2'd0; key_col = 2'd0; end
         4'h2: begin key_row = 2'd0; key_col = 2'd1; end
         4'h3: begin key_row = 2'd0; key_col = 2'd2; end
         4'hC: begin key_row = 2'd0; key_col = 2'd3; end
         4'h4: begin key_row = 2'd1; key_col = 2'd0; end
         4'h5: begin key_row = 2'd1; key_col = 2'd1; end
         4'h6: begin key_row = 2'd1; key_col = 2'd2; end
         4'hD: begin key_row = 2'd1; key_col = 2'd3; end
         4'h7: begin key_row = 2'd2; key_col = 2'd0; end
         4'h8: begin key_row = 2'd2; key_col = 2'd1; end
         4'h9: begin key_row = 2'd2; key_col = 2'd2; end
         4'hE: begin key_row = 2'd2; key_col = 2'd3; end
         4'hA: begin key_row = 2'd3; key_col = 2'd0; end
         4'h0: begin key_row = 2'd3; key_col = 2'd1; end
         4'hB: begin key_row = 2'd3; key_col = 2'd2; end
         default: begin key_row = 2'd3; key_col = 2'd3; end
      endcase
   endtask

   task automatic press(input logic [3:0] k);
      set_key(k);
      key_down = 1'b1;
      repeat (24) tick();
      key_down = 1'b0;
      repeat (10) tick();
   endtask

   task automatic wait_row(input logic [1:0] r);
      logic [3:0] pat;
      pat = ~(4'b1000 >> r);
      for (int i = 0; i < 20 && lin_matriz != pat; i++) tick();
      check("wait_row", {28'd0, lin_matriz}, {28'd0, pat});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_lin"},   {28'd0, lin_matriz},        32'h0000000F);
      check({tag, "_valid"}, {31'd0, dig.digitos_valid}, 32'd0);
      check({tag, "_event"}, {30'd0, dig.digitos_event}, 32'd0);
      check({tag, "_count"}, {29'd0, dig.digitos_count}, 32'd0);
      check({tag, "_value"}, {16'd0, dig.digitos_value}, 32'h0000FFFF);
      check({tag, "_kp"},    {31'd0, dig.key_pressed},   32'd0);
   endtask

   initial begin
      logic [15:0] v0;
      logic [1:0]  e0;
      logic [2:0]  c0;
      bit          stable;
      errors = 0; checks = 0; kp_cnt = 0; post_hs = 1'b0;
      rst = 1'b1; enable = 1'b1; key_down = 1'b0; key_row = 2'd0; key_col = 2'd0;
      dig.digitos_ready = 1'b1;
      tick(); tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // Digits 1,2,3 then confirm
      kp_cnt = 0;
      press(4'h1); press(4'h2); press(4'h3);
      check("kp_123", kp_cnt, 32'd3);
      check("val_123", {16'd0, dig.digitos_value}, 32'h0000F123);
      push_exp(2'd1, 16'hF123, 3);
      press(4'hA);

      // Overflow: six 5s keep four digits but pulse six times
      kp_cnt = 0;
      repeat (6) press(4'h5);
      check("kp_overflow", kp_cnt, 32'd6);
      check("cnt_overflow", {29'd0, dig.digitos_count}, 32'd4);
      push_exp(2'd1, 16'h5555, 4);
      press(4'hA);

      // Bounce on key 1: two short low bursts rejected, four-cycle hold accepted
      kp_cnt = 0;
      set_key(4'h1);
      wait_row(2'd0);
      key_down = 1'b1; tick(); tick();
      key_down = 1'b0; tick();
      key_down = 1'b1; tick(); tick();
      key_down = 1'b0; tick();
      check("bounce_kp", kp_cnt, 32'd0);
      check("bounce_cnt", {29'd0, dig.digitos_count}, 32'd0);
      wait_row(2'd0);
      key_down = 1'b1; repeat (4) tick();
      key_down = 1'b0; repeat (10) tick();
      check("hold_kp", kp_cnt, 32'd1);
      check("hold_val", {16'd0, dig.digitos_value}, 32'h0000FFF1);

      // Timeout with consumer stalled for 50 cycles
      press(4'h7);
      check("val_17", {16'd0, dig.digitos_value}, 32'h0000FF17);
      dig.digitos_ready = 1'b0;
      push_exp(2'd3, 16'hEEEE, -1);
      for (int i = 0; i < 400 && !dig.digitos_valid; i++) tick();
      check("to_valid", {31'd0, dig.digitos_valid}, 32'd1);
      check("to_event", {30'd0, dig.digitos_event}, 32'd3);
      check("to_value", {16'd0, dig.digitos_value}, 32'h0000EEEE);
      v0 = dig.digitos_value; e0 = dig.digitos_event; c0 = dig.digitos_count;
      stable = 1'b1;
      repeat (50) begin
         tick();
         if (!(dig.digitos_valid && dig.digitos_value == v0 && dig.digitos_event == e0 &&
               dig.digitos_count == c0 && lin_matriz == 4'b1111)) stable = 1'b0;
      end
      check("to_stall_stable", {31'd0, stable}, 32'd1);
      dig.digitos_ready = 1'b1;
      sample();
      repeat (5) tick();

      // Clear, then reset in the middle of a debounce
      press(4'h9);
      push_exp(2'd2, 16'hFFFF, -1);
      press(4'hB);
      press(4'h3);
      check("val_3", {16'd0, dig.digitos_value}, 32'h0000FFF3);
      set_key(4'h6);
      wait_row(2'd1);
      key_down = 1'b1; tick(); tick();
      rst = 1'b1; tick();
      check_reset_outputs("rst_mid");
      rst = 1'b0; key_down = 1'b0;
      repeat (3) tick();

      // Enable dropped while a confirm is pending: event lost
      dig.digitos_ready = 1'b0;
      press(4'h2);
      press(4'hA);
      check("pend_valid", {31'd0, dig.digitos_valid}, 32'd1);
      check("pend_event", {30'd0, dig.digitos_event}, 32'd1);
      enable = 1'b0; tick();
      check_reset_outputs("en_drop");
      enable = 1'b1; dig.digitos_ready = 1'b1;
      tick();
      press(4'h8);
      check("after_en_val", {16'd0, dig.digitos_value}, 32'h0000FFF8);

      // Key C: backspace when built with the option, ignored otherwise
      push_exp(2'd2, 16'hFFFF, -1);
      press(4'hB);
      press(4'h4); press(4'h8); press(4'hC);
`ifdef KEYPAD_BACKSPACE_EN
      push_exp(2'd1, 16'hFFF4, 1);
`else
      push_exp(2'd1, 16'hFF48, 2);
`endif
      press(4'hA);

      check("sb_drained", sb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/keypad_scanner_buffered.md
Name: keypad_scanner_buffered

Overview:
Parametrised 4x4 matrix-keypad scanner and digit accumulator for the electronic lock, the next generation of the keypad decoder. It scans rows, debounces both press and release, and shifts digits into a MAX_DIGITS-deep buffer. Confirm, clear and timeout events go to the lock controller through a valid/ready handshake, and each result is held until it is consumed.

Parameters:
MAX_DIGITS, 20, digit buffer depth in nibbles (range 1..32)
DEBOUNCE_CYCLES, 100, consecutive stable cycles required for both press and release
SCAN_DIV, 1, cycles each row is driven before advancing to the next row
TIMEOUT_CYCLES, 5000, idle cycles after the last accepted key before a timeout event

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  block enable; low acts as a synchronous soft reset
col_matriz  in  4  column sense, active low; bit3 = column 0
lin_matriz  out  4  row drive, active low; bit3 = row 0
digitos_value  out  4*MAX_DIGITS  digit buffer; newest digit in [3:0]; unused nibbles 0xF
digitos_count  out  $clog2(MAX_DIGITS+1)  number of digits held
digitos_event  out  2  0 = none, 1 = CONFIRM, 2 = CLEAR, 3 = TIMEOUT
digitos_valid  out  1  event valid; held until handshake
digitos_ready  in  1  consumer accepts the event
key_pressed  out  1  one-cycle pulse on each accepted key

Behaviour:
- Reset (rst=1, priority over enable; or enable=0):
  - state IDLE; buffer all 0xF; count 0; all counters 0
  - digitos_valid 0, event 0, key_pressed 0, lin_matriz 4'b1111
- IDLE: lin_matriz 4'b1111; next cycle goes to SCAN when enable=1.
- SCAN:
  - drives one row low: row r -> bit (3-r) low
  - row advances 0->1->2->3->0 every SCAN_DIV cycles
  - col_matriz != 4'b1111 -> DEBOUNCE; row frozen, column pattern latched
- DEBOUNCE:
  - col_matriz must equal the latched pattern for DEBOUNCE_CYCLES consecutive cycles, then DECODE
  - any mismatch -> SCAN, debounce counter cleared
- DECODE (1 cycle) key map:
  - row0: 1 2 3 C; row1: 4 5 6 D; row2: 7 8 9 E; row3: A(confirm) 0 B(clear) F
  - more than one column low -> ignored, go to RELEASE
  - Digit 0-9, count<MAX_DIGITS:
    - buffer shifts left one nibble; digit enters [3:0]
    - count+1, key_pressed pulses, timeout counter cleared
    - go to RELEASE
  - Digit 0-9, count==MAX_DIGITS: digit dropped, buffer unchanged, key_pressed still pulses, go to RELEASE
  - A -> REPORT with CONFIRM, value = buffer; B -> REPORT with CLEAR, value = all 0xF
  - C/D/E/F ignored, go to RELEASE (C changes with the optional feature)
- RELEASE:
  - row still driven
  - col_matriz == 4'b1111 for DEBOUNCE_CYCLES consecutive cycles -> SCAN
  - any bounce restarts the count
  - no new key is accepted before release completes
- Timeout:
  - counter runs in SCAN only while count>0
  - reaching TIMEOUT_CYCLES -> REPORT with TIMEOUT, value = all 0xE
- REPORT:
  - lin_matriz 4'b1111; digitos_valid=1; event/value/count stable until digitos_valid & digitos_ready
  - on handshake: buffer all 0xF, count 0, timeout counter 0, valid drops next cycle
  - CONFIRM/CLEAR go to RELEASE; TIMEOUT goes to SCAN
  - no scanning or timeout counting while waiting
- Outside REPORT: digitos_event 0; digitos_value mirrors the live buffer.
- Ready held permanently high: handshake completes on the first valid cycle, so REPORT lasts exactly 1 cycle.
- enable dropped mid-REPORT: event lost, full soft reset.

Optional Feature:
KEYPAD_BACKSPACE_EN
- Defined, key C:
  - count>0: deletes newest digit; buffer shifts right one nibble, 0xF enters the top nibble; count-1; key_pressed pulses; timeout counter cleared
  - count==0: no effect
  - either case goes to RELEASE
- Undefined: C ignored like D/E/F.

Test Plan:
MAX_DIGITS=4, DEBOUNCE_CYCLES=4, SCAN_DIV=2, TIMEOUT_CYCLES=200 unless stated.
- Press 1, 2, 3 (each released), then A -> valid=1, event=1, value=16'hF123, count=3; ready pulse -> value 16'hFFFF, count 0.
- Press 5 x6 then A -> value 16'h5555, count=4; key_pressed pulses 6 times.
- Col bounces low 2 cycles, high 1, low 2 -> no key accepted; held low 4 cycles -> key accepted once.
- Press 7, then idle 200 cycles -> event=3, value=16'hEEEE; ready held low 50 cycles keeps valid=1 and outputs stable.
- Press 9 then B -> event=2, value=16'hFFFF; rst asserted mid-DEBOUNCE -> all outputs at reset values next cycle.
- With KEYPAD_BACKSPACE_EN: press 4, 8, C, then A -> value 16'hFFF4, count=1.
